reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 18 +
 rtl/btn_debounce.sv | 46 ++++
 rtl/reset_sequencer.sv | 105 ++++++++++
 tb/tb_reset_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and counter sizing helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_RUN,
    ST_HOLD
  } state_t;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer + debouncer; level changes after DEBOUNCE_CYCLES disagreeing samples.
// Level and press are registered together, two synchronizer stages ahead of the counter.
module btn_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 30000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES, 1, 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [DW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      press  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        // The disagreeing sample completes the run: accept it and restart counting.
        level <= sync_b;
        press <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / pushbutton reset sequencer; out_reset and ready are registered FSM decodes.
// Button path (debounce, HOLD, reset_count) is built only when RESET_SEQ_BTN_EN is defined.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int STARTUP_CYCLES  = 65536,
  parameter int DEBOUNCE_CYCLES = 30000,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn,
  output logic       out_reset,
  output logic       ready,
  output logic [7:0] reset_count
);

  localparam int CW = cnt_width(STARTUP_CYCLES, DEBOUNCE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

`ifdef RESET_SEQ_BTN_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic       level;
  logic       press;
  logic [7:0] count_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .reset_n(reset_n),
    .btn    (btn),
    .level  (level),
    .press  (press)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) reset_count <= 8'd0;
    else          reset_count <= count_nxt;
  end
`else
  logic unused_btn;
  assign unused_btn  = btn;
  assign reset_count = 8'd0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef RESET_SEQ_BTN_EN
    count_nxt = reset_count;
`endif
    case (state)
      ST_STARTUP: begin
        if (cnt == STARTUP_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
`ifdef RESET_SEQ_BTN_EN
        if (press) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          if (reset_count != 8'hFF) count_nxt = reset_count + 8'd1;
        end
`endif
      end
`ifdef RESET_SEQ_BTN_EN
      ST_HOLD: begin
        // Counter parks at its terminal value while the button is still held.
        if (cnt != HOLD_LAST) cnt_nxt = cnt + 1'b1;
        else if (!level)      state_nxt = ST_RUN;
      end
`endif
      default: begin
        state_nxt = ST_STARTUP;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_STARTUP;
      cnt       <= '0;
      out_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_reset <= (state_nxt != ST_RUN);
      ready     <= (state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer against an edge-level behavioural model of the reset rules.
module tb_reset_sequencer;

  localparam int S = 100;
  localparam int D = 8;
  localparam int H = 4;
`ifdef RESET_SEQ_BTN_EN
  localparam bit BTN_EN = 1'b1;
`else
  localparam bit BTN_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn = 1'b0;
  logic       out_reset;
  logic       ready;
  logic [7:0] reset_count;

  int n_chk = 0;
  int n_pass = 0;

  reset_sequencer #(
    .STARTUP_CYCLES (S),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .btn        (btn),
    .out_reset  (out_reset),
    .ready      (ready),
    .reset_count(reset_count)
  );

  always #5 clock = ~clock;

  // Model: mode 0 = starting up, 1 = running, 2 = button reset in progress.
  int   mode = 0;
  int   edge_n = 0;
  int   since_rel = 0;
  int   hold_age = 0;
  int   m_rc = 0;
  bit   lvl = 0;
  int   dis = 0;
  bit   rose = 0;
  bit   bq[$] = '{1'b0, 1'b0};

  function automatic void model_edge(input bit b, input bit rn);
    bit old_lvl, p, s;
    if (!rn) begin
      mode = 0; since_rel = 0; hold_age = 0; m_rc = 0;
      lvl = 0; dis = 0; rose = 0; edge_n = 0;
      bq = '{1'b0, 1'b0};
      return;
    end
    edge_n++;
    old_lvl = lvl;
    p = rose;
    rose = 0;
    if (BTN_EN) begin
      s = bq.pop_front();
      bq.push_back(b);
      if (s != lvl) begin
        dis++;
        if (dis == D) begin lvl = s; dis = 0; rose = s; end
      end else dis = 0;
    end
    case (mode)
      0: begin since_rel++; if (since_rel >= S) mode = 1; end
      1: if (p) begin mode = 2; hold_age = 0; if (m_rc < 255) m_rc++; end
      default: begin hold_age++; if (hold_age >= H && !old_lvl) mode = 1; end
    endcase
  endfunction

  task automatic step(input logic b, input logic rn);
    btn = b;
    reset_n = rn;
    @(posedge clock);
    model_edge(b, rn);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step(1'b0, 1'b0);
    n_chk++;
    if ({out_reset, ready, reset_count} !== {1'b1, 1'b0, 8'd0})
      $display("FAIL reset_state: got out=%b rdy=%b cnt=%0d want out=1 rdy=0 cnt=0", out_reset, ready, reset_count);
    else n_pass++;
  endtask

  task automatic test_power_up();
    logic o99, o100;
    o99 = 1'bx; o100 = 1'bx;
    repeat (120) begin
      step(1'b0, 1'b1);
      if (edge_n == 99) o99 = out_reset;
      if (edge_n == 100) o100 = out_reset;
      n_chk++;
      if ({out_reset, ready, reset_count} !== {mode != 1, mode == 1, 8'(m_rc)})
        $display("FAIL power_up edge %0d: got out=%b rdy=%b cnt=%0d want out=%b rdy=%b cnt=%0d", edge_n, out_reset, ready, reset_count, mode != 1, mode == 1, m_rc);
      else n_pass++;
    end
    n_chk++;
    if ({o99, o100} !== 2'b10) $display("FAIL power_up_edges: got e99=%b e100=%b want e99=1 e100=0", o99, o100);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    logic o209, o210;
    o209 = 1'bx; o210 = 1'bx;
    while (edge_n < 199) step(1'b0, 1'b1);
    for (int i = 0; i < 45; i++) begin
      step(i < 14, 1'b1);
      if (edge_n == 209) o209 = out_reset;
      if (edge_n == 210) o210 = out_reset;
      n_chk++;
      if ({out_reset, ready, reset_count} !== {mode != 1, mode == 1, 8'(m_rc)})
        $display("FAIL clean_press edge %0d: got out=%b rdy=%b cnt=%0d want out=%b rdy=%b cnt=%0d", edge_n, out_reset, ready, reset_count, mode != 1, mode == 1, m_rc);
      else n_pass++;
    end
    n_chk++;
    if ({o209, o210, reset_count} !== {1'b0, BTN_EN, 8'(BTN_EN)})
      $display("FAIL clean_press_latency: got e209=%b e210=%b cnt=%0d want e209=0 e210=%b cnt=%0d", o209, o210, reset_count, BTN_EN, BTN_EN);
    else n_pass++;
  endtask

  task automatic test_long_hold();
    for (int i = 0; i < 85; i++) begin
      step(i < 50, 1'b1);
      n_chk++;
      if ({out_reset, ready, reset_count} !== {mode != 1, mode == 1, 8'(m_rc)})
        $display("FAIL long_hold edge %0d: got out=%b rdy=%b cnt=%0d want out=%b rdy=%b cnt=%0d", edge_n, out_reset, ready, reset_count, mode != 1, mode == 1, m_rc);
      else n_pass++;
    end
    n_chk++;
    if ({out_reset, reset_count} !== {1'b0, 8'(2 * BTN_EN)})
      $display("FAIL long_hold_end: got out=%b cnt=%0d want out=0 cnt=%0d", out_reset, reset_count, 2 * BTN_EN);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int rc0;
    rc0 = m_rc;
    repeat (12) begin
      int hi, lo;
      hi = $urandom_range(1, D - 1);
      lo = $urandom_range(1, 6);
      for (int i = 0; i < hi + lo; i++) begin
        step(i < hi, 1'b1);
        n_chk++;
        if ({out_reset, ready, reset_count} !== {mode != 1, mode == 1, 8'(m_rc)})
          $display("FAIL glitch edge %0d: got out=%b rdy=%b cnt=%0d want out=%b rdy=%b cnt=%0d", edge_n, out_reset, ready, reset_count, mode != 1, mode == 1, m_rc);
        else n_pass++;
      end
    end
    n_chk++;
    if ({out_reset, reset_count} !== {1'b0, 8'(rc0)})
      $display("FAIL glitch_end: got out=%b cnt=%0d want out=0 cnt=%0d", out_reset, reset_count, rc0);
    else n_pass++;
  endtask

  task automatic test_startup_press_and_midhold_reset();
    step(1'b0, 1'b0);
    for (int i = 0; i < 115; i++) begin
      step(i >= 10 && i < 30, 1'b1);
      n_chk++;
      if ({out_reset, ready, reset_count} !== {mode != 1, mode == 1, 8'(m_rc)})
        $display("FAIL startup_press edge %0d: got out=%b rdy=%b cnt=%0d want out=%b rdy=%b cnt=%0d", edge_n, out_reset, ready, reset_count, mode != 1, mode == 1, m_rc);
      else n_pass++;
    end
    n_chk++;
    if ({ready, reset_count} !== {1'b1, 8'd0})
      $display("FAIL startup_press_ignored: got rdy=%b cnt=%0d want rdy=1 cnt=0", ready, reset_count);
    else n_pass++;
    repeat (12) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    n_chk++;
    if ({out_reset, ready, reset_count} !== {1'b1, 1'b0, 8'd0})
      $display("FAIL midhold_reset: got out=%b rdy=%b cnt=%0d want out=1 rdy=0 cnt=0", out_reset, ready, reset_count);
    else n_pass++;
    for (int i = 0; i < 110; i++) begin
      step(1'b0, 1'b1);
      n_chk++;
      if ({out_reset, ready, reset_count} !== {mode != 1, mode == 1, 8'(m_rc)})
        $display("FAIL restart edge %0d: got out=%b rdy=%b cnt=%0d want out=%b rdy=%b cnt=%0d", edge_n, out_reset, ready, reset_count, mode != 1, mode == 1, m_rc);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    repeat (260) begin
      int hi, lo;
      hi = $urandom_range(10, 13);
      lo = $urandom_range(12, 16);
      for (int i = 0; i < hi + lo; i++) begin
        step(i < hi, 1'b1);
        n_chk++;
        if ({out_reset, ready, reset_count} !== {mode != 1, mode == 1, 8'(m_rc)})
          $display("FAIL saturation edge %0d: got out=%b rdy=%b cnt=%0d want out=%b rdy=%b cnt=%0d", edge_n, out_reset, ready, reset_count, mode != 1, mode == 1, m_rc);
        else n_pass++;
      end
    end
    n_chk++;
    if (reset_count !== 8'(255 * BTN_EN))
      $display("FAIL saturation_end: got cnt=%0d want cnt=%0d", reset_count, 255 * BTN_EN);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_clean_press();
    test_long_hold();
    test_glitch();
    test_startup_press_and_midhold_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
